mod_inverse: RTL and testbench

Sequential modular inverter. It is the inverse-direction companion to the combinational `multiplier` (twiddle_factor * data_in mod modulus): given a and an odd modulus q, it returns a^-1 mod q. The binary extended-Euclid algorithm runs one step per clock. It is used to derive inverse twiddle factors and the n^-1 scaling constant for the INTT path, and as a check on `multiplier` results.

---
 rtl/mod_inverse.sv | 179 +++++++++++++++++
 tb/tb_mod_inverse.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_inverse.sv
// mod_inverse: sequential modular inverter, result = data_in^-1 mod modulus.
// Runs the binary extended-Euclid algorithm, one reduction step per clock.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   in_valid   request valid
//   in_ready   block can accept a request (high only in IDLE)
//   data_in    operand a
//   modulus    modulus q (must be odd and >= 3)
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     a^-1 mod q, 0 when error is set
//   error      no inverse exists or the input was illegal; qualified by out_valid
//   busy       high while the iteration is running
module mod_inverse #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_ITER = 4 * WIDTH + 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] modulus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             error,
    output logic             busy
);

    localparam int unsigned IW = $clog2(MAX_ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] u, u_nx;
    logic [WIDTH-1:0] v, v_nx;
    logic [WIDTH-1:0] x1, x1_nx;
    logic [WIDTH-1:0] x2, x2_nx;
    logic [WIDTH-1:0] q, q_nx;
    logic [IW-1:0]    iter, iter_nx;
    logic [WIDTH-1:0] result_nx;
    logic             error_nx;
    logic             illegal;

    // Divide by two modulo odd q: odd values get q added first (WIDTH+1 bit sum).
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] m);
        logic [WIDTH:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return s[WIDTH:1];
    endfunction

    // (a - b) mod m for a, b in [0, m-1]; the wrapped difference plus m is exact.
    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH-1:0] d;
        d = a - b;
        return (a < b) ? (d + m) : d;
    endfunction

    // Requests with no defined inverse computation bypass RUN.
    always_comb begin
        illegal = (modulus[0] == 1'b0) || (modulus < WIDTH'(3)) ||
                  (data_in == '0) || (data_in >= modulus);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            u         <= '0;
            v         <= '0;
            x1        <= '0;
            x2        <= '0;
            q         <= '0;
            iter      <= '0;
            result    <= '0;
            error     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            u         <= u_nx;
            v         <= v_nx;
            x1        <= x1_nx;
            x2        <= x2_nx;
            q         <= q_nx;
            iter      <= iter_nx;
            result    <= result_nx;
            error     <= error_nx;
            in_ready  <= (state_nx == IDLE);
            out_valid <= (state_nx == DONE);
            busy      <= (state_nx == RUN);
        end
    end

    // Next-state and datapath step.
    always_comb begin
        state_nx  = state;
        u_nx      = u;
        v_nx      = v;
        x1_nx     = x1;
        x2_nx     = x2;
        q_nx      = q;
        iter_nx   = iter;
        result_nx = result;
        error_nx  = error;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    q_nx = modulus;
                    if (illegal) begin
                        result_nx = '0;
                        error_nx  = 1'b1;
                        state_nx  = DONE;
                    end else begin
                        u_nx     = data_in;
                        v_nx     = modulus;
                        x1_nx    = WIDTH'(1);
                        x2_nx    = '0;
                        iter_nx  = '0;
                        state_nx = RUN;
                    end
                end
            end

            RUN: begin
                iter_nx = iter + IW'(1);
                if (u == WIDTH'(1)) begin
                    result_nx = x1;
                    error_nx  = 1'b0;
                    state_nx  = DONE;
                end else if (v == WIDTH'(1)) begin
                    result_nx = x2;
                    error_nx  = 1'b0;
                    state_nx  = DONE;
                end else if ((u == '0) || (v == '0) || (iter == IW'(MAX_ITER))) begin
                    // Zero means gcd(a,q) != 1; the iteration cap is only a safety net.
                    result_nx = '0;
                    error_nx  = 1'b1;
                    state_nx  = DONE;
                end else if (!u[0]) begin
                    u_nx  = u >> 1;
                    x1_nx = half_mod(x1, q);
                end else if (!v[0]) begin
                    v_nx  = v >> 1;
                    x2_nx = half_mod(x2, q);
                end else if (u >= v) begin
                    u_nx  = u - v;
                    x1_nx = sub_mod(x1, x2, q);
                end else begin
                    v_nx  = v - u;
                    x2_nx = sub_mod(x2, x1, q);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mod_inverse.sv
// tb_mod_inverse: directed and swept checks of mod_inverse at WIDTH=16.
module tb_mod_inverse;

    localparam int unsigned W     = 16;
    localparam int unsigned MAXIT = 4 * W + 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_in;
    logic [W-1:0] modulus;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         error;
    logic         busy;

    int vectors;
    int miscompares;

    mod_inverse #(.WIDTH(W), .MAX_ITER(MAXIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .modulus   (modulus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .error     (error),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Extended Euclid on signed integers; independent of the binary algorithm.
    function automatic void model(input longint a, input longint q,
                                  output logic [W-1:0] r, output logic e);
        longint t, nt, rr, nr, qt, tmp;
        t = 0; nt = 1; rr = q; nr = a;
        while (nr != 0) begin
            qt  = rr / nr;
            tmp = t - qt * nt;  t  = nt; nt = tmp;
            tmp = rr - qt * nr; rr = nr; nr = tmp;
        end
        if (rr != 1) begin
            e = 1'b1; r = '0;
        end else begin
            if (t < 0) t = t + q;
            e = 1'b0; r = W'(t);
        end
    endfunction

    // Drive one request; cyc counts clock edges from capture to out_valid (999 on timeout).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] q,
                         output int cyc, output logic [W-1:0] r, output logic e);
        @(negedge clk);
        data_in  = a;
        modulus  = q;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = '0;
        modulus  = '0;
        cyc      = 1;
        while (!out_valid && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) cyc = 999;
        r = result;
        e = error;
        if (out_ready && out_valid) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data_in = '0; modulus = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready, out_valid, busy, error, result} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL reset: rdy=%b ov=%b busy=%b err=%b res=%0d, required 1 0 0 0 0",
                     in_ready, out_valid, busy, error, result);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] av [4] = '{16'd1, 16'd2, 16'd7680, 16'd17};
        logic [W-1:0] ev [4] = '{16'd1, 16'd3841, 16'd7680, 16'd2711};
        int cyc; logic [W-1:0] r; logic e;
        for (int i = 0; i < 4; i++) begin
            issue(av[i], 16'd7681, cyc, r, e);
            vectors++;
            if (r !== ev[i] || e !== 1'b0) begin
                miscompares++;
                $display("FAIL basic a=%0d: res=%0d err=%b, required %0d 0", av[i], r, e, ev[i]);
            end
            vectors++;
            if ((32'(r) * 32'(av[i])) % 32'd7681 != 32'd1) begin
                miscompares++;
                $display("FAIL basic_product a=%0d: res*a mod q=%0d, required 1",
                         av[i], (32'(r) * 32'(av[i])) % 32'd7681);
            end
            if (i == 0) begin
                vectors++;
                if (cyc > 3) begin
                    miscompares++;
                    $display("FAIL basic_latency a=1: %0d cycles, required <= 3", cyc);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [W-1:0] av [4] = '{16'd0, 16'd7681, 16'd5, 16'd0};
        logic [W-1:0] qv [4] = '{16'd7681, 16'd7681, 16'd7680, 16'd1};
        int cyc; logic [W-1:0] r; logic e;
        for (int i = 0; i < 4; i++) begin
            issue(av[i], qv[i], cyc, r, e);
            vectors++;
            if (r !== 16'd0 || e !== 1'b1 || cyc != 1) begin
                miscompares++;
                $display("FAIL illegal q=%0d a=%0d: res=%0d err=%b cyc=%0d, required 0 1 1",
                         qv[i], av[i], r, e, cyc);
            end
        end
    endtask

    task automatic test_gcd();
        int cyc; logic [W-1:0] r; logic e;
        issue(16'd6, 16'd15, cyc, r, e);
        vectors++;
        // Six RUN steps: u/2, v-=u, v/2, v/2, u-=v -> 0, zero detect.
        if (r !== 16'd0 || e !== 1'b1 || cyc != 7) begin
            miscompares++;
            $display("FAIL gcd q=15 a=6: res=%0d err=%b cyc=%0d, required 0 1 7", r, e, cyc);
        end
    endtask

    task automatic test_handshake();
        int cyc;
        out_ready = 1'b0;
        @(negedge clk);
        data_in = 16'd17; modulus = 16'd7681; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        data_in = 16'd2; modulus = 16'd7681; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; data_in = '0; modulus = '0;
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hs_run: busy=%b in_ready=%b, required 1 0", busy, in_ready);
        end
        cyc = 0;
        while (!out_valid && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if (!out_valid) begin
            miscompares++;
            $display("FAIL hs_timeout: out_valid=%b, required 1", out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || result !== 16'd2711 || error !== 1'b0 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hs_hold[%0d]: ov=%b res=%0d err=%b rdy=%b, required 1 2711 0 0",
                         i, out_valid, result, error, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hs_release: ov=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL hs_no_queue[%0d]: ov=%b busy=%b, required 0 0", i, out_valid, busy);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc; logic [W-1:0] r; logic e;
        @(negedge clk);
        data_in = 16'd17; modulus = 16'd7681; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({in_ready, out_valid, busy, error, result} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL reset_mid_run: rdy=%b ov=%b busy=%b err=%b res=%0d, required 1 0 0 0 0",
                     in_ready, out_valid, busy, error, result);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(16'd2, 16'd7681, cyc, r, e);
        vectors++;
        if (r !== 16'd3841 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset a=2: res=%0d err=%b, required 3841 0", r, e);
        end
    endtask

    task automatic test_random_sweep();
        int cyc; logic [W-1:0] r, er; logic e, ee;
        logic [W-1:0] q, a;
        for (int i = 0; i < 1000; i++) begin
            q = W'($urandom_range(65535, 3)) | W'(1);
            a = W'($urandom_range(32'(q) - 1, 1));
            model(longint'(a), longint'(q), er, ee);
            issue(a, q, cyc, r, e);
            vectors++;
            if (r !== er || e !== ee || cyc > int'(MAXIT) + 2) begin
                miscompares++;
                $display("FAIL sweep q=%0d a=%0d: res=%0d err=%b cyc=%0d, required %0d %b",
                         q, a, r, e, cyc, er, ee);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_illegal();
        test_gcd();
        test_handshake();
        test_reset_mid_run();
        test_random_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
